acc_cpu_param: RTL and testbench

ACC_CPU_PARAM -- requirements
Module: acc_cpu_param

---
 rtl/acc_cpu_param.sv | 161 ++++++++++++++++
 tb/tb_acc_cpu_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_param.sv
// Parameterised accumulator CPU: FETCH/EXEC/HALT sequencer with a single memory port.
// Define ACC_CPU_TRAP_EN to make opcode 1110 trap into HALT and raise the illegal output.
module acc_cpu_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] address,
   output logic              mem_req,
   output logic              we,
   output logic              halted
`ifdef ACC_CPU_TRAP_EN
   ,
   output logic              illegal
`endif
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SHL  = 4'h2;
   localparam logic [3:0] OP_SHR  = 4'h3;
   localparam logic [3:0] OP_LDI  = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_BR   = 4'h8;
   localparam logic [3:0] OP_AND  = 4'h9;
   localparam logic [3:0] OP_SUB  = 4'hA;
   localparam logic [3:0] OP_BRZ  = 4'hB;
   localparam logic [3:0] OP_BRN  = 4'hC;
   localparam logic [3:0] OP_XOR  = 4'hD;
   localparam logic [3:0] OP_TRAP = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] ac_q, ac_d;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic              is_mem_op;
   logic [DATA_W-1:0] mem_result;

   assign opcode  = ir_q[DATA_W-1 -: 4];
   assign operand = ir_q[ADDR_W-1:0];

   generate
      if (DATA_W > ADDR_W + 4) begin : g_ir_pad
         logic unused_ir_mid;
         assign unused_ir_mid = ^ir_q[DATA_W-5:ADDR_W];
      end
   endgenerate

   always_comb begin
      is_mem_op = opcode inside {OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
                                 OP_ST, OP_AND, OP_SUB, OP_XOR};
   end

   // Oversized shift amounts are clamped explicitly so wide data_in never aliases.
   always_comb begin
      mem_result = ac_q;
      case (opcode)
         OP_ADD:  mem_result = ac_q + data_in;
         OP_SUB:  mem_result = ac_q - data_in;
         OP_SHL:  mem_result = (data_in >= SHIFT_LIMIT) ? '0 : (ac_q << data_in);
         OP_SHR:  mem_result = (data_in >= SHIFT_LIMIT) ? '0 : (ac_q >> data_in);
         OP_LD:   mem_result = data_in;
         OP_OR:   mem_result = ac_q | data_in;
         OP_AND:  mem_result = ac_q & data_in;
         OP_XOR:  mem_result = ac_q ^ data_in;
         default: mem_result = ac_q;
      endcase
   end

`ifdef ACC_CPU_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ac_d    = ac_q;
`ifdef ACC_CPU_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = data_in;
               pc_d    = pc_q + 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_mem_op) begin
               if (mem_ready) begin
                  ac_d    = mem_result;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_FETCH;
               case (opcode)
                  OP_LDI:  ac_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                  OP_BR:   pc_d = operand;
                  OP_BRZ:  if (ac_q == '0) pc_d = operand;
                  OP_BRN:  if (ac_q[DATA_W-1]) pc_d = operand;
                  OP_HALT: state_d = S_HALT;
                  OP_TRAP: begin
`ifdef ACC_CPU_TRAP_EN
                     state_d   = S_HALT;
                     illegal_d = 1'b1;
`endif
                  end
                  default: state_d = S_FETCH;
               endcase
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         ac_q    <= '0;
`ifdef ACC_CPU_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
`ifdef ACC_CPU_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign data_out = ac_q;
   assign address  = (state_q == S_EXEC) ? operand : pc_q;
   assign mem_req  = (state_q == S_FETCH) || ((state_q == S_EXEC) && is_mem_op);
   assign we       = (state_q == S_EXEC) && (opcode == OP_ST);
   assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: single-instruction vector table plus multi-cycle sequences.
module tb_acc_cpu_param;

   logic        clock;
   logic        reset_n;
   logic [31:0] data_in;
   logic        mem_ready;
   logic [31:0] data_out;
   logic [15:0] address;
   logic        mem_req;
   logic        we;
   logic        halted;
`ifdef ACC_CPU_TRAP_EN
   logic        illegal;
`endif

   logic [31:0] mem [0:65535];
   int          checks;
   int          failures;
   int          wr_count;

   acc_cpu_param #(.DATA_W(32), .ADDR_W(16)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .data_in   (data_in),
      .mem_ready (mem_ready),
      .data_out  (data_out),
      .address   (address),
      .mem_req   (mem_req),
      .we        (we),
      .halted    (halted)
`ifdef ACC_CPU_TRAP_EN
      ,
      .illegal   (illegal)
`endif
   );

   assign data_in = mem[address];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] arg;
      logic [31:0] init;
      logic [31:0] opnd;
      logic [31:0] exp_ac;
      logic [15:0] exp_addr;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge, applying any write the DUT strobes.
   task automatic tick();
      logic        do_wr;
      logic [15:0] wa;
      logic [31:0] wd;
      #4;
      do_wr = mem_req && we && mem_ready;
      wa    = address;
      wd    = data_out;
      @(posedge clock);
      #1;
      if (do_wr) begin
         mem[wa] = wd;
         wr_count++;
      end
      @(negedge clock);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   vec_t vecs[18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      wr_count  = 0;
      reset_n   = 1'b0;
      mem_ready = 1'b1;

      vecs[0]  = '{4'h1, 16'h0040, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 16'h0002};
      vecs[1]  = '{4'hA, 16'h0040, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 16'h0002};
      vecs[2]  = '{4'h2, 16'h0040, 32'h0000_FFFF, 32'd16,        32'hFFFF_0000, 16'h0002};
      vecs[3]  = '{4'h2, 16'h0040, 32'h0000_FFFF, 32'd40,        32'h0000_0000, 16'h0002};
      vecs[4]  = '{4'h3, 16'h0040, 32'h8000_0000, 32'd31,        32'h0000_0001, 16'h0002};
      vecs[5]  = '{4'h3, 16'h0040, 32'hFFFF_FFFF, 32'd32,        32'h0000_0000, 16'h0002};
      vecs[6]  = '{4'h6, 16'h0040, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 16'h0002};
      vecs[7]  = '{4'h9, 16'h0040, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 16'h0002};
      vecs[8]  = '{4'hD, 16'h0040, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 16'h0002};
      vecs[9]  = '{4'h5, 16'h0040, 32'h0000_0003, 32'h1234_5678, 32'h1234_5678, 16'h0002};
      vecs[10] = '{4'h4, 16'hBEEF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_BEEF, 16'h0002};
      vecs[11] = '{4'h8, 16'h0040, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 16'h0040};
      vecs[12] = '{4'hB, 16'h0040, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 16'h0002};
      vecs[13] = '{4'hB, 16'h0040, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 16'h0040};
      vecs[14] = '{4'hC, 16'h0020, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 16'h0020};
      vecs[15] = '{4'hC, 16'h0020, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 16'h0002};
      vecs[16] = '{4'h0, 16'h0040, 32'h0000_0077, 32'h0000_0000, 32'h0000_0077, 16'h0002};
      vecs[17] = '{4'h7, 16'h0041, 32'h0000_CAFE, 32'h0000_0000, 32'h0000_CAFE, 16'h0002};

      @(negedge clock);

      // Reset state, both while asserted and right after release
      chk("rst_mem_req", {31'b0, mem_req}, 32'd1);
      chk("rst_address", {16'b0, address}, 32'd0);
      chk("rst_we", {31'b0, we}, 32'd0);
      do_reset();
      chk("rel_address", {16'b0, address}, 32'd0);
      chk("rel_data_out", data_out, 32'd0);
      chk("rel_halted", {31'b0, halted}, 32'd0);
      chk("rel_mem_req", {31'b0, mem_req}, 32'd1);

      // Table: LD init, then op under test, then check AC and next fetch address
      for (int i = 0; i < 18; i++) begin
         do_reset();
         mem[16'h0000] = 32'h5000_0100;
         mem[16'h0100] = vecs[i].init;
         mem[16'h0001] = {vecs[i].op, 12'h000, vecs[i].arg};
         mem[vecs[i].arg] = vecs[i].opnd;
         mem[16'h0002] = 32'hF000_0000;
         ticks(4);
         chk($sformatf("vec%0d_ac", i), data_out, vecs[i].exp_ac);
         chk($sformatf("vec%0d_addr", i), {16'b0, address}, {16'b0, vecs[i].exp_addr});
         chk($sformatf("vec%0d_fetch_req", i), {31'b0, mem_req}, 32'd1);
      end
      chk("st_mem_written", mem[16'h0041], 32'h0000_CAFE);

      // Small program: LDI 5, ADD [0x10], ST [0x11], HALT
      do_reset();
      mem[16'h0000] = 32'h4000_0005;
      mem[16'h0001] = 32'h1000_0010;
      mem[16'h0002] = 32'h7000_0011;
      mem[16'h0003] = 32'hF000_0000;
      mem[16'h0010] = 32'd7;
      ticks(7);
      chk("prog_not_halted_7", {31'b0, halted}, 32'd0);
      tick();
      chk("prog_halted_8", {31'b0, halted}, 32'd1);
      chk("prog_mem11", mem[16'h0011], 32'd12);
      chk("prog_data_out", data_out, 32'd12);
      chk("prog_halt_req", {31'b0, mem_req}, 32'd0);
      ticks(3);
      chk("prog_halt_hold", {31'b0, halted}, 32'd1);
      chk("prog_halt_ac", data_out, 32'd12);
      chk("prog_halt_we", {31'b0, we}, 32'd0);

      // Wait states during fetch and during ST
      do_reset();
      mem[16'h0000] = 32'h4000_0021;
      mem[16'h0001] = 32'h7000_0030;
      mem[16'h0002] = 32'hF000_0000;
      mem[16'h0030] = 32'h0000_DEAD;
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("fwait%0d_addr", k), {16'b0, address}, 32'd0);
         chk($sformatf("fwait%0d_ac", k), data_out, 32'd0);
         chk($sformatf("fwait%0d_req", k), {31'b0, mem_req}, 32'd1);
      end
      mem_ready = 1'b1;
      ticks(3);
      mem_ready = 1'b0;
      begin
         int w0;
         w0 = wr_count;
         chk("st_we", {31'b0, we}, 32'd1);
         chk("st_addr", {16'b0, address}, 32'h30);
         for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("swait%0d_we", k), {31'b0, we}, 32'd1);
            chk($sformatf("swait%0d_req", k), {31'b0, mem_req}, 32'd1);
            chk($sformatf("swait%0d_addr", k), {16'b0, address}, 32'h30);
            chk($sformatf("swait%0d_ac", k), data_out, 32'h21);
            chk($sformatf("swait%0d_nowr", k), wr_count, w0);
         end
         mem_ready = 1'b1;
         tick();
         chk("st_one_write", wr_count, w0 + 1);
         chk("st_mem30", mem[16'h0030], 32'h21);
         chk("st_next_fetch", {16'b0, address}, 32'd2);
         chk("st_we_low", {31'b0, we}, 32'd0);
         ticks(2);
         chk("ws_halted", {31'b0, halted}, 32'd1);
      end

      // Asynchronous reset during a stalled ST
      do_reset();
      mem[16'h0000] = 32'h4000_0021;
      mem[16'h0001] = 32'h7000_0030;
      mem[16'h0002] = 32'hF000_0000;
      mem[16'h0030] = 32'h0000_DEAD;
      ticks(3);
      mem_ready = 1'b0;
      tick();
      begin
         int w0;
         w0 = wr_count;
         chk("ar_st_we_before", {31'b0, we}, 32'd1);
         #2 reset_n = 1'b0;
         #1;
         chk("ar_we_drop", {31'b0, we}, 32'd0);
         chk("ar_addr0", {16'b0, address}, 32'd0);
         chk("ar_req", {31'b0, mem_req}, 32'd1);
         chk("ar_ac0", data_out, 32'd0);
         @(negedge clock);
         @(negedge clock);
         reset_n = 1'b1;
         chk("ar_no_write", wr_count, w0);
         chk("ar_mem30", mem[16'h0030], 32'h0000_DEAD);
         chk("ar_fetch_addr", {16'b0, address}, 32'd0);
         mem_ready = 1'b1;
         tick();
         chk("ar_refetch_ldi", {16'b0, address}, 32'h21);
      end

      // PC wrap at 0xFFFF
      do_reset();
      mem[16'h0000] = 32'h8000_FFFF;
      mem[16'hFFFF] = 32'h0000_0000;
      ticks(2);
      chk("wrap_fetch_ffff", {16'b0, address}, 32'h0000_FFFF);
      ticks(2);
      chk("wrap_to_zero", {16'b0, address}, 32'h0000_0000);

      // Opcode 1110
      do_reset();
      mem[16'h0000] = 32'hE000_0000;
      mem[16'h0001] = 32'hF000_0000;
      ticks(2);
`ifdef ACC_CPU_TRAP_EN
      chk("trap_halted", {31'b0, halted}, 32'd1);
      chk("trap_illegal", {31'b0, illegal}, 32'd1);
      chk("trap_req", {31'b0, mem_req}, 32'd0);
`else
      chk("op_e_nop_halted", {31'b0, halted}, 32'd0);
      chk("op_e_nop_addr", {16'b0, address}, 32'd1);
      ticks(2);
      chk("op_e_then_halt", {31'b0, halted}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
